// File: rtl/addsub_pkg.sv
// Shared types and constant helpers for the digit-serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  // Upper bound on WIDTH so saturation constants can come from plain functions.
  localparam int unsigned MaxWidth = 64;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MaxWidth-1:0] sat_smax(input int unsigned w);
    return (MaxWidth'(1) << (w - 1)) - MaxWidth'(1);
  endfunction

  function automatic logic [MaxWidth-1:0] sat_smin(input int unsigned w);
    return MaxWidth'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry adder slice; also exposes the carry into its top bit.
module addsub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic c;
    c     = cin;
    c_msb = cin;
    s_d   = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (i == int'(DIGIT) - 1) c_msb = c;
      s_d[i] = a_d[i] ^ b_d[i] ^ c;
      c      = (a_d[i] & b_d[i]) | (c & (a_d[i] ^ b_d[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit: WIDTH/DIGIT cycles per operation, valid/ready on both sides,
// optional signed/unsigned saturation.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             op_signed,
  input  logic             op_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned N = WIDTH / DIGIT;
  localparam int unsigned CntW = cnt_w(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
  localparam logic [MaxWidth-1:0] SMaxFull = sat_smax(WIDTH);
  localparam logic [MaxWidth-1:0] SMinFull = sat_smin(WIDTH);
  localparam logic [WIDTH-1:0] SMax = SMaxFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMin = SMinFull[WIDTH-1:0];

  if ((WIDTH < 2) || (WIDTH > MaxWidth) || (DIGIT == 0) || ((WIDTH % DIGIT) != 0))
  begin : gen_bad_params
    $error("addsub_serial: WIDTH must be >= 2, <= MaxWidth and a multiple of DIGIT");
  end

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cy_q, cy_d;
  logic              sub_q, sub_d;
  logic              sgn_q, sgn_d;
  logic              sat_q, sat_d;
  logic              carry_q, carry_d;
  logic              overflow_q, overflow_d;

  logic [DIGIT-1:0]  b_eff;
  logic [DIGIT-1:0]  s_dig;
  logic              cout_dig;
  logic              cmsb_dig;

  assign b_eff = opb_q[DIGIT-1:0] ^ {DIGIT{sub_q}};

  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_d   (opa_q[DIGIT-1:0]),
    .b_d   (b_eff),
    .cin   (cy_q),
    .s_d   (s_dig),
    .cout  (cout_dig),
    .c_msb (cmsb_dig)
  );

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sat_val;
  logic             raw_carry;
  logic             raw_ovf;
  logic             accept;

  always_comb begin
    acc_next  = (acc_q >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
    raw_carry = cout_dig ^ sub_q;
    raw_ovf   = cmsb_dig ^ cout_dig;
    accept    = in_valid && in_ready;

    // On signed overflow the wrapped MSB is the inverse of the true sign.
    sat_val = acc_next;
    if (sgn_q && raw_ovf) begin
      sat_val = acc_next[WIDTH-1] ? SMax : SMin;
    end else if (!sgn_q && raw_carry) begin
      sat_val = sub_q ? '0 : '1;
    end

    state_d    = state_q;
    cnt_d      = cnt_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    result_d   = result_q;
    cy_d       = cy_q;
    sub_d      = sub_q;
    sgn_d      = sgn_q;
    sat_d      = sat_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StRun: begin
        opa_d = opa_q >> DIGIT;
        opb_d = opb_q >> DIGIT;
        acc_d = acc_next;
        cy_d  = cout_dig;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d    = StDone;
          result_d   = sat_q ? sat_val : acc_next;
          carry_d    = raw_carry;
          overflow_d = raw_ovf;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A fresh accept may also occur in DONE in the same cycle as the output handshake.
    if (accept) begin
      state_d = StRun;
      cnt_d   = '0;
      opa_d   = a;
      opb_d   = b;
      cy_d    = op_sub;
      sub_d   = op_sub;
      sgn_d   = op_signed;
      sat_d   = op_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      cy_q       <= 1'b0;
      sub_q      <= 1'b0;
      sgn_q      <= 1'b0;
      sat_q      <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      cy_q       <= cy_d;
      sub_q      <= sub_d;
      sgn_q      <= sgn_d;
      sat_q      <= sat_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed self-checking bench for addsub_serial: 8-bit/1-bit-digit and 16-bit/4-bit-digit instances.
module tb_addsub_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0, result8;
  logic        sub8 = 1'b0, sgn8 = 1'b0, sat8 = 1'b0, carry8, ovf8, busy8;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, result16;
  logic        sub16 = 1'b0, sgn16 = 1'b0, sat16 = 1'b0, carry16, ovf16, busy16;

  int n_checks = 0;
  int n_fail   = 0;

  addsub_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .op_sub(sub8), .op_signed(sgn8), .op_sat(sat8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .carry(carry8), .overflow(ovf8), .busy(busy8)
  );

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
    .op_sub(sub16), .op_signed(sgn16), .op_sat(sat16), .out_valid(out_valid16),
    .out_ready(out_ready16), .result(result16), .carry(carry16), .overflow(ovf16),
    .busy(busy16)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one op on dut8 (out_ready assumed high) and returns the result and latency.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                     input logic tg, input logic tt, output logic [7:0] r, output logic c,
                     output logic o, output int lat);
    a8 = ta; b8 = tb_; sub8 = ts; sgn8 = tg; sat8 = tt; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result8; c = carry8; o = ovf8;
    @(posedge clk); #1;
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                      input logic tg, input logic tt, output logic [15:0] r, output logic c,
                      output logic o, output int lat);
    a16 = ta; b16 = tb_; sub16 = ts; sgn16 = tg; sat16 = tt; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result16; c = carry16; o = ovf16;
    @(posedge clk); #1;
  endtask

  function automatic void model16(input logic [15:0] ta, input logic [15:0] tb_,
                                  input logic s, input logic g, input logic t,
                                  output logic [15:0] r, output logic c, output logic o);
    logic [16:0] raw;
    raw = s ? ({1'b0, ta} - {1'b0, tb_}) : ({1'b0, ta} + {1'b0, tb_});
    r = raw[15:0];
    c = raw[16];
    o = s ? ((ta[15] != tb_[15]) && (r[15] != ta[15]))
          : ((ta[15] == tb_[15]) && (r[15] != ta[15]));
    if (t) begin
      if (g && o) r = r[15] ? 16'h7FFF : 16'h8000;
      else if (!g && c) r = s ? 16'h0000 : 16'hFFFF;
    end
  endfunction

  typedef struct {
    logic [7:0] a, b;
    logic       s, g, t;
    logic [7:0] r;
    logic       c, o;
  } vec8_t;

  vec8_t vecs[$] = '{
    '{8'd100, 8'd30,  1'b1, 1'b1, 1'b0, 8'd70,  1'b0, 1'b0},
    '{8'h80,  8'h01,  1'b1, 1'b1, 1'b0, 8'h7F,  1'b0, 1'b1},
    '{8'h80,  8'h01,  1'b1, 1'b1, 1'b1, 8'h80,  1'b0, 1'b1},
    '{8'd5,   8'd10,  1'b1, 1'b0, 1'b0, 8'hFB,  1'b1, 1'b0},
    '{8'd5,   8'd10,  1'b1, 1'b0, 1'b1, 8'h00,  1'b1, 1'b0},
    '{8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 8'h2C,  1'b1, 1'b0},
    '{8'd200, 8'd100, 1'b0, 1'b0, 1'b1, 8'hFF,  1'b1, 1'b0},
    '{8'd100, 8'd100, 1'b0, 1'b1, 1'b1, 8'h7F,  1'b0, 1'b1}
  };

  initial begin
    logic [7:0]  r8;
    logic [15:0] r16, er16;
    logic        c, o, ec, eo;
    int          lat;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(out_valid8), 32'd0);
    check_val("rst_in_ready",  32'(in_ready8),  32'd1);
    check_val("rst_busy",      32'(busy8),      32'd0);
    check_val("rst_result",    32'(result8),    32'd0);
    check_val("rst_flags",     32'({carry8, ovf8}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].g, vecs[i].t, r8, c, o, lat);
      check_val($sformatf("v%0d_lat", i),    32'(lat), 32'd8);
      check_val($sformatf("v%0d_result", i), 32'(r8),  32'(vecs[i].r));
      check_val($sformatf("v%0d_carry", i),  32'(c),   32'(vecs[i].c));
      check_val($sformatf("v%0d_ovf", i),    32'(o),   32'(vecs[i].o));
    end

    // Backpressure: hold DONE for 5 cycles, then chain a new op on the handshake cycle.
    out_ready8 = 1'b0;
    a8 = 8'd50; b8 = 8'd25; sub8 = 1'b0; sgn8 = 1'b0; sat8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check_val("bp_busy_run", 32'(busy8), 32'd1);
    a8 = 8'd1; b8 = 8'd1; sub8 = 1'b1;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("bp_lat", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_val("bp_hold_valid",  32'(out_valid8), 32'd1);
      check_val("bp_hold_result", 32'(result8),    32'd75);
      check_val("bp_hold_flags",  32'({carry8, ovf8}), 32'd0);
      check_val("bp_in_ready",    32'(in_ready8),  32'd0);
    end
    a8 = 8'd9; b8 = 8'd4; sub8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    #1;
    check_val("bp_chain_ready", 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check_val("bp_chain_run", 32'({busy8, out_valid8}), 32'b10);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("bp_chain_lat",    32'(lat),     32'd8);
    check_val("bp_chain_result", 32'(result8), 32'd13);
    @(posedge clk); #1;

    // Reset during RUN discards the operation immediately.
    a8 = 8'd60; b8 = 8'd20; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid",  32'(out_valid8), 32'd0);
    check_val("mid_rst_ready",  32'(in_ready8),  32'd1);
    check_val("mid_rst_busy",   32'(busy8),      32'd0);
    check_val("mid_rst_result", 32'(result8),    32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op8(8'd7, 8'd3, 1'b1, 1'b0, 1'b0, r8, c, o, lat);
    check_val("post_rst_lat",    32'(lat), 32'd8);
    check_val("post_rst_result", 32'(r8),  32'd4);

    // 16-bit, 4-bit digit instance.
    op16(16'h1234, 16'h0FFF, 1'b1, 1'b1, 1'b0, r16, c, o, lat);
    check_val("w16_lat",    32'(lat), 32'd4);
    check_val("w16_result", 32'(r16), 32'h0235);
    check_val("w16_flags",  32'({c, o}), 32'd0);
    for (int k = 0; k < 16; k++) begin
      logic [15:0] ra, rb;
      logic [2:0]  m;
      ra = 16'($urandom);
      rb = 16'($urandom);
      m  = 3'($urandom);
      model16(ra, rb, m[0], m[1], m[2], er16, ec, eo);
      op16(ra, rb, m[0], m[1], m[2], r16, c, o, lat);
      check_val($sformatf("rnd%0d_lat", k),    32'(lat), 32'd4);
      check_val($sformatf("rnd%0d_result", k), 32'(r16), 32'(er16));
      check_val($sformatf("rnd%0d_flags", k),  32'({c, o}), 32'({ec, eo}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
